pll_lock_sequencer: RTL and testbench

//   Drives the Reset input of a PLL_CycloneV instance and watches its Locked output.

---
 rtl/pll_lock_sequencer.sv | 110 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock with timeout
// and retry, qualifies lock stability, then raises ready_o as a downstream reset release.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET_PLL | pll_reset_o high for ResetCycles cycles
// WAIT_LOCK | reset released, waiting for synchronised lock or timeout
// STABILISE | lock seen, must stay high for StableCycles cycles
// RUN       | ready_o high; any loss of lock restarts the sequence
module pll_lock_sequencer #(
   parameter int ResetCycles   = 16,
   parameter int TimeoutCycles = 50000,
   parameter int StableCycles  = 1024
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       locked_i,
   output logic       pll_reset_o,
   output logic       ready_o,
   output logic [1:0] state_o,
   output logic [7:0] timeout_count_o,
   output logic [7:0] lock_loss_count_o
);

   localparam int MaxRt     = (ResetCycles > TimeoutCycles) ? ResetCycles : TimeoutCycles;
   localparam int MaxCycles = (MaxRt > StableCycles) ? MaxRt : StableCycles;
   localparam int CntW      = $clog2(MaxCycles) + 1;

   localparam logic [CntW-1:0] ResetLast   = CntW'(ResetCycles - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
   localparam logic [CntW-1:0] StableLast  = CntW'(StableCycles - 1);

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILISE = 2'd2,
      RUN       = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      timeout_cnt_q, timeout_cnt_d;
   logic [7:0]      loss_cnt_q, loss_cnt_d;
   logic            sync1_q, sync2_q;
   logic            pll_reset_q, ready_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      timeout_cnt_d = timeout_cnt_q;
      loss_cnt_d    = loss_cnt_q;
      case (state_q)
         RESET_PLL: begin
            if (cnt_q == ResetLast) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (sync2_q) begin
               state_d = STABILISE;
            end else if (cnt_q == TimeoutLast) begin
               state_d = RESET_PLL;
               if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
            end
         end
         STABILISE: begin
            if (!sync2_q) state_d = WAIT_LOCK;
            else if (cnt_q == StableLast) state_d = RUN;
         end
         RUN: begin
            // Counter idles in RUN so it can never overflow while locked.
            cnt_d = '0;
            if (!sync2_q) begin
               state_d = RESET_PLL;
               if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
            end
         end
         default: state_d = RESET_PLL;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= RESET_PLL;
         cnt_q         <= '0;
         timeout_cnt_q <= 8'd0;
         loss_cnt_q    <= 8'd0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         pll_reset_q   <= 1'b1;
         ready_q       <= 1'b0;
      end else begin
         sync1_q       <= locked_i;
         sync2_q       <= sync1_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         loss_cnt_q    <= loss_cnt_d;
         // Outputs decode the next state so they move on the same edge as state_q.
         pll_reset_q   <= (state_d == RESET_PLL);
         ready_q       <= (state_d == RUN);
      end
   end

   assign pll_reset_o       = pll_reset_q;
   assign ready_o           = ready_q;
   assign state_o           = state_q;
   assign timeout_count_o   = timeout_cnt_q;
   assign lock_loss_count_o = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues expected snapshots
// tagged with an edge number, a negedge monitor pops and compares them.
module tb_pll_lock_sequencer;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       locked_i;
   logic       pll_reset_o;
   logic       ready_o;
   logic [1:0] state_o;
   logic [7:0] timeout_count_o;
   logic [7:0] lock_loss_count_o;

   pll_lock_sequencer #(
      .ResetCycles  (4),
      .TimeoutCycles(20),
      .StableCycles (8)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .locked_i         (locked_i),
      .pll_reset_o      (pll_reset_o),
      .ready_o          (ready_o),
      .state_o          (state_o),
      .timeout_count_o  (timeout_count_o),
      .lock_loss_count_o(lock_loss_count_o)
   );

   always #10 clk_i = ~clk_i;

   int edge_n = 0;
   always @(posedge clk_i) edge_n <= edge_n + 1;

   typedef struct {
      int         at;
      string      nm;
      logic [1:0] st;
      logic       pll;
      logic       rdy;
      logic [7:0] tc;
      logic [7:0] llc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic push(input int at, input string nm, input logic [1:0] st,
                       input logic pll, input logic rdy, input logic [7:0] tc,
                       input logic [7:0] llc);
      exp_t e;
      e.at = at; e.nm = nm; e.st = st; e.pll = pll; e.rdy = rdy; e.tc = tc; e.llc = llc;
      sb.push_back(e);
   endtask

   task automatic wait_edge(input int target);
      while (edge_n < target) @(negedge clk_i);
   endtask

   always @(negedge clk_i) begin
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         if (e.at < edge_n) begin
            bad++;
            $display("FAIL %s: sample for edge %0d missed, now edge %0d", e.nm, e.at, edge_n);
         end else if ({state_o, pll_reset_o, ready_o, timeout_count_o, lock_loss_count_o} !==
                      {e.st, e.pll, e.rdy, e.tc, e.llc}) begin
            bad++;
            $display("FAIL %s @edge %0d: got st=%0d pll=%b rdy=%b tc=%0d llc=%0d, want st=%0d pll=%b rdy=%b tc=%0d llc=%0d",
                     e.nm, e.at, state_o, pll_reset_o, ready_o, timeout_count_o, lock_loss_count_o,
                     e.st, e.pll, e.rdy, e.tc, e.llc);
         end
      end
   end

   // One lock/lose cycle starting at the negedge after RESET_PLL entry edge e.
   task automatic lose_cycle(inout int e, inout int llc, input string nm);
      locked_i = 1'b1;
      push(e + 13, {nm, "_run"}, 2'd3, 1'b0, 1'b1, 8'd0, 8'(llc));
      llc = (llc >= 255) ? 255 : llc + 1;
      push(e + 17, {nm, "_loss"}, 2'd0, 1'b1, 1'b0, 8'd0, 8'(llc));
      wait_edge(e + 14);
      locked_i = 1'b0;
      wait_edge(e + 17);
      e = e + 17;
   endtask

   initial begin
      int b, n, e, llc;
      reset_i  = 1'b1;
      locked_i = 1'b0;
      repeat (3) @(negedge clk_i);

      // Locked high throughout
      locked_i = 1'b1;
      b = edge_n + 1;
      push(b, "t1_reset", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      for (int k = 1; k <= 3; k++) push(b + k, "t1_hold", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      push(b + 4,  "t1_wait",    2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 5,  "t1_stab",    2'd2, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 12, "t1_pre_run", 2'd2, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 13, "t1_run",     2'd3, 1'b0, 1'b1, 8'd0, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      wait_edge(b + 15);

      // Locked low throughout: timeout retries
      locked_i = 1'b0;
      reset_i  = 1'b1;
      b = edge_n + 1;
      push(b + 3,  "t2_pulse1_end", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      push(b + 4,  "t2_wait1",      2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 23, "t2_wait1_end",  2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 24, "t2_retry1",     2'd0, 1'b1, 1'b0, 8'd1, 8'd0);
      push(b + 27, "t2_pulse2_end", 2'd0, 1'b1, 1'b0, 8'd1, 8'd0);
      push(b + 28, "t2_wait2",      2'd1, 1'b0, 1'b0, 8'd1, 8'd0);
      push(b + 48, "t2_retry2",     2'd0, 1'b1, 1'b0, 8'd2, 8'd0);
      push(b + 72, "t2_retry3",     2'd0, 1'b1, 1'b0, 8'd3, 8'd0);
      push(b + 76, "t2_wait4",      2'd1, 1'b0, 1'b0, 8'd3, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      wait_edge(b + 77);

      // One-cycle lock drop while stabilising at counter=5
      locked_i = 1'b1;
      reset_i  = 1'b1;
      b = edge_n + 1;
      push(b + 10, "t3_stab_cnt5", 2'd2, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 11, "t3_back_wait", 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 12, "t3_restab",    2'd2, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 19, "t3_pre_run",   2'd2, 1'b0, 1'b0, 8'd0, 8'd0);
      push(b + 20, "t3_run",       2'd3, 1'b0, 1'b1, 8'd0, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      wait_edge(b + 8);
      locked_i = 1'b0;
      wait_edge(b + 9);
      locked_i = 1'b1;
      wait_edge(b + 22);

      // Lock loss in RUN
      n = edge_n;
      locked_i = 1'b0;
      push(n + 1, "t4_edge1", 2'd3, 1'b0, 1'b1, 8'd0, 8'd0);
      push(n + 2, "t4_edge2", 2'd3, 1'b0, 1'b1, 8'd0, 8'd0);
      push(n + 3, "t4_lost",  2'd0, 1'b1, 1'b0, 8'd0, 8'd1);
      wait_edge(n + 3);

      // 300 further lock losses: count saturates
      e = n + 3;
      llc = 1;
      for (int i = 0; i < 300; i++) lose_cycle(e, llc, "t5");
      push(e + 10, "t5_hold", 2'd1, 1'b0, 1'b0, 8'd0, 8'd255);
      wait_edge(e + 11);

      // Reset while in RUN with three lock losses recorded
      locked_i = 1'b1;
      reset_i  = 1'b1;
      b = edge_n + 1;
      push(b + 13, "t6_run0", 2'd3, 1'b0, 1'b1, 8'd0, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      wait_edge(b + 14);
      locked_i = 1'b0;
      push(b + 17, "t6_loss1", 2'd0, 1'b1, 1'b0, 8'd0, 8'd1);
      wait_edge(b + 17);
      e = b + 17;
      llc = 1;
      for (int i = 0; i < 2; i++) lose_cycle(e, llc, "t6");
      locked_i = 1'b1;
      push(e + 13, "t6_run3",    2'd3, 1'b0, 1'b1, 8'd0, 8'd3);
      push(e + 14, "t6_pre_rst", 2'd3, 1'b0, 1'b1, 8'd0, 8'd3);
      wait_edge(e + 14);
      reset_i = 1'b1;
      push(e + 15, "t6_reset", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      push(e + 16, "t6_after", 2'd0, 1'b1, 1'b0, 8'd0, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      wait_edge(e + 17);

      for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk_i);
      while (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         total++;
         bad++;
         $display("FAIL %s: never sampled (edge %0d pending, now %0d)", x.nm, x.at, edge_n);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not complete, edge %0d", edge_n);
      $fatal(1, "watchdog expired");
   end

endmodule
